// File: rtl/timer_pkg.sv
// Register map offsets and CTRL bit positions shared by the timer block.
// Byte offsets within the 32-byte window; only Adr[4:2] participate in decode.
package timer_pkg;

    localparam logic [4:0] OFS_CTRL     = 5'h00;
    localparam logic [4:0] OFS_LOAD     = 5'h04;
    localparam logic [4:0] OFS_COUNT    = 5'h08;
    localparam logic [4:0] OFS_STATUS   = 5'h0C;
    localparam logic [4:0] OFS_PRESCALE = 5'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: tick pulses for one cycle every div+1 enabled clocks; pc holds while disabled.
// tick is combinational from registered state; clr restarts the period from zero.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] pc_q, pc_d;

    assign tick = en & (pc_q == div);

    always_comb begin
        pc_d = pc_q;
        if (clr || tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and W1C expiry flag.
// Writes land on the next clock edge; reads are combinational; Irq comes only from registers.
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          PRE_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Irq
);

    logic             en_q, en_d;
    logic             ar_q, ar_d;
    logic             ie_q, ie_d;
    logic [31:0]      load_q, load_d;
    logic [31:0]      count_q, count_d;
    logic             exp_q, exp_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;

    logic       sel;
    logic [4:0] ofs;
    logic       we_ctrl, we_load, we_status, we_prescale;
    logic       start;
    logic       tick;
    logic       unused_adr;

    assign sel = (Adr[31:5] == BASE_ADDR[31:5]);
    assign ofs = {Adr[4:2], 2'b00};
    assign unused_adr = ^Adr[1:0];

    assign we_ctrl     = MemWrite & sel & (ofs == OFS_CTRL);
    assign we_load     = MemWrite & sel & (ofs == OFS_LOAD);
    assign we_status   = MemWrite & sel & (ofs == OFS_STATUS);
    assign we_prescale = MemWrite & sel & (ofs == OFS_PRESCALE);

    // Only a 0->1 EN edge restarts; 1->1 rewrites must leave count and pc alone.
    assign start = we_ctrl & WriteData[CTRL_EN] & ~en_q;

    timer_prescaler #(.W(PRE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .clr   (start),
        .div   (prescale_q),
        .tick  (tick)
    );

    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        ie_d       = ie_q;
        load_d     = load_q;
        count_d    = count_q;
        exp_d      = exp_q;
        prescale_d = prescale_q;

        if (we_ctrl) begin
            en_d = WriteData[CTRL_EN];
            ar_d = WriteData[CTRL_AR];
            ie_d = WriteData[CTRL_IE];
        end
        if (we_load) begin
            load_d = WriteData;
        end
        if (we_prescale) begin
            prescale_d = WriteData[PRE_W-1:0];
        end
        if (we_status && WriteData[0]) begin
            exp_d = 1'b0;
        end

        // Expiry is applied after bus writes so that set beats W1C and one-shot beats EN rewrite.
        if (start) begin
            count_d = load_q;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                count_d = load_q;
                exp_d   = 1'b1;
                if (!ar_q) begin
                    en_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            exp_q      <= 1'b0;
            prescale_q <= '0;
        end else begin
            en_q       <= en_d;
            ar_q       <= ar_d;
            ie_q       <= ie_d;
            load_q     <= load_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            prescale_q <= prescale_d;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (sel) begin
            case (ofs)
                OFS_CTRL:     ReadData = {29'h0, ie_q, ar_q, en_q};
                OFS_LOAD:     ReadData = load_q;
                OFS_COUNT:    ReadData = count_q;
                OFS_STATUS:   ReadData = {31'h0, exp_q};
                OFS_PRESCALE: ReadData = 32'(prescale_q);
                default:      ReadData = 32'h0;
            endcase
        end
    end

    assign Irq = exp_q & ie_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: a script table of writes, idles and read checks, then corner sequences.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_LOAD = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_PRE  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Irq       (Irq)
    );

    typedef enum int {OP_WR, OP_IDLE, OP_CHK} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        irq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input op_e op, input logic [31:0] a, input logic [31:0] d,
                                input logic i, input string nm);
        vec_t v;
        v.op = op; v.adr = a; v.dat = d; v.irq = i; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Adr = a; WriteData = d; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                       input string nm);
        MemWrite = 1'b0; Adr = a;
        #1;
        n_tests++;
        if (ReadData !== exp_rd || Irq !== exp_irq) begin
            n_fail++;
            $display("FAIL %s: got ReadData=%h Irq=%b, want ReadData=%h Irq=%b",
                     nm, ReadData, Irq, exp_rd, exp_irq);
        end
    endtask

    initial begin
        // reset state
        add(OP_CHK,  A_CTRL, 32'h0, 1'b0, "rst_ctrl");
        add(OP_CHK,  A_LOAD, 32'h0, 1'b0, "rst_load");
        add(OP_CHK,  A_CNT,  32'h0, 1'b0, "rst_count");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "rst_status");
        add(OP_CHK,  A_PRE,  32'h0, 1'b0, "rst_prescale");
        // one-shot, PRESCALE=0, LOAD=3
        add(OP_WR,   A_PRE,  32'd0, 1'b0, "");
        add(OP_WR,   A_LOAD, 32'd3, 1'b0, "");
        add(OP_WR,   A_CTRL, 32'h1, 1'b0, "");
        add(OP_IDLE, 0,      32'd3, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "os_exp_not_yet");
        add(OP_CHK,  A_CNT,  32'h0, 1'b0, "os_count_zero");
        add(OP_IDLE, 0,      32'd1, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h1, 1'b0, "os_exp_at_4");
        add(OP_CHK,  A_CTRL, 32'h0, 1'b0, "os_en_cleared");
        add(OP_CHK,  A_CNT,  32'h3, 1'b0, "os_count_reloaded");
        // auto-reload, PRESCALE=4, LOAD=2, IE: expiries at 15, 30, 45, ...
        add(OP_WR,   A_STAT, 32'h1, 1'b0, "");
        add(OP_WR,   A_PRE,  32'd4, 1'b0, "");
        add(OP_WR,   A_LOAD, 32'd2, 1'b0, "");
        add(OP_WR,   A_CTRL, 32'h7, 1'b0, "");
        add(OP_IDLE, 0,      32'd14, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "ar_exp_not_yet_14");
        add(OP_IDLE, 0,      32'd1, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h1, 1'b1, "ar_exp_at_15");
        add(OP_CHK,  A_CNT,  32'h2, 1'b1, "ar_count_reloaded");
        add(OP_CHK,  A_CTRL, 32'h7, 1'b1, "ar_still_enabled");
        add(OP_WR,   A_STAT, 32'h1, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "w1c_clears");
        add(OP_IDLE, 0,      32'd13, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "ar_exp_not_yet_29");
        add(OP_IDLE, 0,      32'd1, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h1, 1'b1, "ar_exp_at_30");
        // W1C on the expiry cycle (45)
        add(OP_WR,   A_STAT, 32'h1, 1'b0, "");
        add(OP_IDLE, 0,      32'd13, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h0, 1'b0, "pre_collide_44");
        add(OP_WR,   A_STAT, 32'h1, 1'b0, "");
        add(OP_CHK,  A_STAT, 32'h1, 1'b1, "set_beats_w1c");
        // LOAD write on the reload tick (60): old LOAD used, new one at 75
        add(OP_IDLE, 0,      32'd14, 1'b0, "");
        add(OP_WR,   A_LOAD, 32'd9, 1'b0, "");
        add(OP_CHK,  A_CNT,  32'h2, 1'b1, "reload_uses_old_load");
        add(OP_CHK,  A_LOAD, 32'h9, 1'b1, "load_updated");
        add(OP_IDLE, 0,      32'd15, 1'b0, "");
        add(OP_CHK,  A_CNT,  32'h9, 1'b1, "reload_uses_new_load");
        add(OP_IDLE, 0,      32'd5, 1'b0, "");
        add(OP_CHK,  A_CNT,  32'h8, 1'b1, "count_after_reload");
        // decode
        add(OP_CHK,  BASE + 32'h14, 32'h0, 1'b1, "unmapped_14");
        add(OP_CHK,  BASE + 32'h1C, 32'h0, 1'b1, "unmapped_1c");
        add(OP_CHK,  BASE + 32'h20, 32'h0, 1'b1, "outside_window");
        add(OP_WR,   A_CTRL, 32'h0, 1'b0, "");
        add(OP_CHK,  A_CTRL, 32'h0, 1'b0, "stopped");
        add(OP_WR,   A_CNT,  32'h1234, 1'b0, "");
        add(OP_CHK,  A_CNT,  32'h8, 1'b0, "count_ro");
        add(OP_WR,   BASE + 32'h20, 32'h7, 1'b0, "");
        add(OP_CHK,  A_CTRL, 32'h0, 1'b0, "outside_write_ignored");
        add(OP_CHK,  BASE + 32'h07, 32'h9, 1'b0, "low_adr_bits_ignored");

        idle(2);
        reset = 1'b1;
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:   wr(vecs[i].adr, vecs[i].dat);
                OP_IDLE: idle(int'(vecs[i].dat));
                default: chk(vecs[i].adr, vecs[i].dat, vecs[i].irq, vecs[i].name);
            endcase
        end

        // asynchronous reset in the middle of a count
        wr(A_LOAD, 32'd5);
        wr(A_CTRL, 32'h5);
        idle(2);
        reset = 1'b0;
        chk(A_CTRL, 32'h0, 1'b0, "midrst_ctrl");
        chk(A_LOAD, 32'h0, 1'b0, "midrst_load");
        chk(A_CNT,  32'h0, 1'b0, "midrst_count");
        chk(A_STAT, 32'h0, 1'b0, "midrst_status");
        chk(A_PRE,  32'h0, 1'b0, "midrst_prescale");
        reset = 1'b1;
        idle(10);
        chk(A_CTRL, 32'h0, 1'b0, "postrst_stopped");
        chk(A_CNT,  32'h0, 1'b0, "postrst_count");

        // EN 1->1 rewrite leaves count running; EN=0 write on one-shot expiry
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        idle(2);
        chk(A_CNT, 32'd8, 1'b0, "run_count_8");
        wr(A_CTRL, 32'h5);
        chk(A_CNT,  32'd7, 1'b0, "en_rewrite_keeps_count");
        chk(A_CTRL, 32'h5, 1'b0, "en_rewrite_ctrl");
        idle(7);
        chk(A_CNT,  32'd0, 1'b0, "count_hits_zero");
        chk(A_STAT, 32'h0, 1'b0, "no_exp_before_tick");
        wr(A_CTRL, 32'h4);
        chk(A_STAT, 32'h1, 1'b1, "stop_and_expire_exp");
        chk(A_CTRL, 32'h4, 1'b1, "stop_and_expire_ctrl");
        chk(A_CNT,  32'd10, 1'b1, "stop_and_expire_reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
